pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_reset is held high per PLL start attempt.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock before a retry.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: lock timeouts tolerated before the FAIL state.
REQ-005 The port list SHALL be exactly:
- clk  in  1  free-running 27 MHz reference clock; single clock domain.
- reset  in  1  synchronous, active-high block reset.
- pll_lock  in  1  asynchronous lock flag from the SDRAM rPLL.
- pll_reset  out  1  drives the rPLL reset input.
- sys_reset  out  1  active-high reset for the SDRAM/downstream logic.
- ready  out  1  PLL locked and stable; downstream released.
- error  out  1  PLL failed to lock after MAX_RETRIES timeouts.
- relock_count  out  8  saturating count of lock losses seen in RUN.

Function
REQ-006 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-007 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL; all outputs registered, updated on the same edge as the state change.
REQ-008 PLL_RST: pll_reset=1, sys_reset=1, ready=0; after exactly RST_CYCLES cycles go to WAIT_LOCK.
REQ-009 WAIT_LOCK: pll_reset=0, sys_reset=1. lock_s=1 -> STABLE with stable counter cleared. Timeout counter reaching LOCK_TIMEOUT-1 -> increment retry counter, go to PLL_RST.
REQ-010 A timeout with retry counter already equal to MAX_RETRIES-1 SHALL go to FAIL instead.
REQ-011 STABLE: lock_s=0 -> WAIT_LOCK, timeout counter restarted, no retry increment. Counter reaching STABLE_CYCLES-1 -> RUN.
REQ-012 RUN: sys_reset=0, ready=1, retry counter cleared.
REQ-013 RUN with lock_s=0: go to PLL_RST, with sys_reset=1 and ready=0 on the next edge; relock_count increments, saturating at 255.
REQ-014 FAIL SHALL be terminal until reset: pll_reset=1, sys_reset=1, ready=0, error=1.
REQ-015 Counters SHALL be sized with clog2 of their parameter and SHALL never wrap.
REQ-016 Resulting latency: ready rises STABLE_CYCLES+2 edges after the first edge that samples pll_lock=1, provided lock stays high.

Reset
REQ-017 On reset=1 at an edge, the block SHALL enter PLL_RST with all counters, synchronizer flops and relock_count cleared.
REQ-018 Reset values: pll_reset=1, sys_reset=1, ready=0, error=0, relock_count=0.
REQ-019 Reset asserted in any state, including mid-RUN or FAIL, SHALL take effect on that same edge.

Configuration
REQ-020 With macro PLL_SEQ_RELOCK_COUNT_EN defined, relock_count SHALL behave per REQ-013.
REQ-021 Without PLL_SEQ_RELOCK_COUNT_EN, relock_count SHALL be tied to 0 and its counter SHALL be omitted; all other behaviour is unchanged.

Structure
REQ-022 Package pll_seq_pkg SHALL hold the FSM state enum typedef and the RELOCK_W=8 constant.
REQ-023 The synchronizer SHALL be a sub-module named sync_2ff, instantiated once.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-024 Nominal start: release reset, raise pll_lock 3 cycles after pll_reset falls and hold it -> pll_reset high exactly 4 cycles; ready=1 and sys_reset=0 exactly 10 edges after pll_lock is first sampled high.
REQ-025 Lock glitch: drop pll_lock for 1 cycle at STABLE count 5 -> FSM returns to WAIT_LOCK; ready delayed by the glitch plus a full 8-cycle stable window; retry count unchanged.
REQ-026 Lock never asserts: hold pll_lock=0 -> two 4-cycle pll_reset pulses spaced by 20-cycle waits; error=1 after the second timeout; pll_reset stays 1; ready stays 0.
REQ-027 Lock loss in RUN: drop pll_lock -> sys_reset=1 and ready=0 within 3 edges; new 4-cycle pll_reset pulse; relock_count 0->1 with the macro, stays 0 without it.
REQ-028 Reset mid-RUN and in FAIL: assert reset for 1 cycle -> next edge gives pll_reset=1, sys_reset=1, ready=0, error=0, relock_count=0; the sequence then restarts per REQ-024.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared sequencer state type, relock counter width and
// counter-width helper for pll_lock_sequencer.
package pll_seq_pkg;

    localparam int unsigned RELOCK_W = 8;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } seq_state_t;

    // Keeps degenerate parameters (1) from producing zero-width counters.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level input,
// cleared by the synchronous block reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: rPLL reset pulse, lock wait with retry/timeout, stability
// window and lock-loss recovery. Define PLL_SEQ_RELOCK_COUNT_EN for relock_count.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic                sys_reset,
    output logic                ready,
    output logic                error,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int unsigned RST_W = cnt_w(RST_CYCLES);
    localparam int unsigned TMO_W = cnt_w(LOCK_TIMEOUT);
    localparam int unsigned STB_W = cnt_w(STABLE_CYCLES);
    localparam int unsigned RTY_W = cnt_w(MAX_RETRIES);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    seq_state_t       state, state_nxt;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
    logic [RTY_W-1:0] retry_cnt, retry_cnt_nxt;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        stb_cnt_nxt   = stb_cnt;
        retry_cnt_nxt = retry_cnt;
        case (state)
            PLL_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt   = WAIT_LOCK;
                    tmo_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins over the retry.
                if (lock_s) begin
                    state_nxt   = STABLE;
                    stb_cnt_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    if (retry_cnt == RTY_LAST) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt     = PLL_RST;
                        rst_cnt_nxt   = '0;
                        retry_cnt_nxt = retry_cnt + RTY_W'(1);
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt   = WAIT_LOCK;
                    tmo_cnt_nxt = '0;
                end else if (stb_cnt == STB_LAST) begin
                    state_nxt = RUN;
                end else begin
                    stb_cnt_nxt = stb_cnt + STB_W'(1);
                end
            end
            RUN: begin
                retry_cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt   = PLL_RST;
                    rst_cnt_nxt = '0;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt   = PLL_RST;
                rst_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLL_RST;
            rst_cnt   <= '0;
            tmo_cnt   <= '0;
            stb_cnt   <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            stb_cnt   <= stb_cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
            pll_reset <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
            sys_reset <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            error     <= (state_nxt == FAIL);
        end
    end

`ifdef PLL_SEQ_RELOCK_COUNT_EN
    logic                relock_evt;
    logic [RELOCK_W-1:0] relock_q;

    assign relock_evt = (state == RUN) && !lock_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            relock_q <= '0;
        end else if (relock_evt && (relock_q != '1)) begin
            relock_q <= relock_q + RELOCK_W'(1);
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: table vectors, multi-cycle corner sequences and
// random lock stimulus checked against a phase/timer reference model.
module tb_pll_lock_sequencer;

    localparam int RST   = 4;
    localparam int TMO   = 20;
    localparam int STB   = 8;
    localparam int MAXR  = 2;

    logic       clk;
    logic       rst_i;
    logic       lock_i;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       error;
    logic [7:0] relock_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk          (clk),
        .reset        (rst_i),
        .pll_lock     (lock_i),
        .pll_reset    (pll_reset),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .error        (error),
        .relock_count (relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a phase label, cycles spent in it, and tallies.
    typedef enum int {M_HOLD, M_SEEK, M_SETTLE, M_LIVE, M_DEAD} mphase_t;
    mphase_t m_phase = M_HOLD;
    int      m_t = 0;
    int      m_timeouts = 0;
    int      m_losses = 0;
    bit      m_q[$] = '{1'b0, 1'b0};

    function automatic void model_step(input bit rst, input bit lk);
        bit ls;
        if (rst) begin
            m_phase = M_HOLD; m_t = 0; m_timeouts = 0; m_losses = 0;
            m_q = '{1'b0, 1'b0};
            return;
        end
        ls = m_q.pop_front();
        m_q.push_back(lk);
        case (m_phase)
            M_HOLD: begin
                m_t++;
                if (m_t == RST) begin m_phase = M_SEEK; m_t = 0; end
            end
            M_SEEK: begin
                if (ls) begin
                    m_phase = M_SETTLE; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == TMO) begin
                        m_t = 0;
                        m_timeouts++;
                        m_phase = (m_timeouts == MAXR) ? M_DEAD : M_HOLD;
                    end
                end
            end
            M_SETTLE: begin
                if (!ls) begin
                    m_phase = M_SEEK; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == STB) m_phase = M_LIVE;
                end
            end
            M_LIVE: begin
                m_timeouts = 0;
                if (!ls) begin
                    m_phase = M_HOLD; m_t = 0;
                    if (m_losses < 255) m_losses++;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int exp_relock();
`ifdef PLL_SEQ_RELOCK_COUNT_EN
        return m_losses;
`else
        return 0;
`endif
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst_i, lock_i);
        #1;
        chk("model pll_reset", {31'b0, pll_reset}, {31'b0, (m_phase == M_HOLD) || (m_phase == M_DEAD)});
        chk("model sys_reset", {31'b0, sys_reset}, {31'b0, m_phase != M_LIVE});
        chk("model ready",     {31'b0, ready},     {31'b0, m_phase == M_LIVE});
        chk("model error",     {31'b0, error},     {31'b0, m_phase == M_DEAD});
        chk("model relock_count", {24'b0, relock_count}, exp_relock());
    endtask

    typedef struct {
        bit rst;
        bit lock;
        int n;
        bit pr;
        bit sr;
        bit rdy;
        bit err;
    } vec_t;

    vec_t vt[7];

    task automatic run_table(input string tag);
        for (int r = 0; r < 7; r++) begin
            rst_i  = vt[r].rst;
            lock_i = vt[r].lock;
            for (int k = 0; k < vt[r].n; k++) tick();
            chk($sformatf("%s row%0d pll_reset", tag, r), {31'b0, pll_reset}, {31'b0, vt[r].pr});
            chk($sformatf("%s row%0d sys_reset", tag, r), {31'b0, sys_reset}, {31'b0, vt[r].sr});
            chk($sformatf("%s row%0d ready", tag, r),     {31'b0, ready},     {31'b0, vt[r].rdy});
            chk($sformatf("%s row%0d error", tag, r),     {31'b0, error},     {31'b0, vt[r].err});
            chk($sformatf("%s row%0d relock_count", tag, r), {24'b0, relock_count}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int lat;
        int first_err;
        int ready_hits;
        bit pr[60];
        bit er[60];
        int seg[$];
        bit cur;
        int len;

        rst_i  = 1'b1;
        lock_i = 1'b0;

        // Nominal start: 4-cycle pll_reset, lock raised 3 cycles after it
        // falls, ready exactly 10 edges after lock is first sampled.
        vt[0] = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0};

        run_table("start");
        repeat (3) tick();

        // Lock loss in RUN.
        lock_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (sys_reset !== 1'b1 && n < 10);
        chk("loss edges to sys_reset", n, 3);
        chk("loss ready low", {31'b0, ready}, 0);
`ifdef PLL_SEQ_RELOCK_COUNT_EN
        chk("loss relock_count", {24'b0, relock_count}, 1);
`else
        chk("loss relock_count", {24'b0, relock_count}, 0);
`endif
        n = 0;
        while (pll_reset === 1'b1 && n < 30) begin n++; tick(); end
        chk("loss pll_reset pulse", n, RST);

        // One-cycle lock glitch while the stability count is 5.
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            lock_i = (i != 7);
            tick();
            if (ready === 1'b1) begin lat = i; break; end
        end
        chk("glitch ready latency", lat, 18);

        // Reset mid-RUN, then full restart.
        run_table("midrun");

        // Lock never asserts.
        rst_i = 1'b1; lock_i = 1'b0;
        tick();
        rst_i = 1'b0;
        pr[0] = pll_reset; er[0] = error;
        for (int i = 1; i < 60; i++) begin
            tick();
            pr[i] = pll_reset; er[i] = error;
        end
        first_err = -1;
        ready_hits = 0;
        for (int i = 0; i < 60; i++) if (er[i] && first_err < 0) first_err = i;
        chk("never first error edge", first_err, 48);
        cur = pr[0]; len = 1;
        for (int i = 1; i < 60; i++) begin
            if (pr[i] == cur) len++;
            else begin seg.push_back(len); cur = pr[i]; len = 1; end
        end
        seg.push_back(len);
        chk("never starts high", {31'b0, pr[0]}, 1);
        chk("never segment count", seg.size(), 5);
        chk("never pulse1", (seg.size() > 0) ? seg[0] : -1, RST);
        chk("never wait1",  (seg.size() > 1) ? seg[1] : -1, TMO);
        chk("never pulse2", (seg.size() > 2) ? seg[2] : -1, RST);
        chk("never wait2",  (seg.size() > 3) ? seg[3] : -1, TMO);
        chk("never ends high", {31'b0, pr[59]}, 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready === 1'b1) ready_hits++;
        end
        chk("never ready hits", ready_hits, 0);
        chk("fail error held", {31'b0, error}, 1);

        // Reset from FAIL, then full restart.
        run_table("fromfail");

        // Random lock behaviour with occasional resets.
        for (int s = 0; s < 150; s++) begin
            int r;
            int rl;
            bit lv;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                rst_i = 1'b1; tick(); rst_i = 1'b0;
                continue;
            end
            lv = (r < 70);
            if (lv) rl = int'($urandom_range(1, 40));
            else if (r < 90) rl = int'($urandom_range(1, 4));
            else rl = int'($urandom_range(20, 90));
            lock_i = lv;
            repeat (rl) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
